dfd_trace_deframer: RTL and testbench
=====================================

Name: dfd_trace_deframer

Overview:
- Receive-side counterpart of the trace packetizer's frame mode.
- Consumes a byte stream of fixed-length frames padded at the tail with a fill byte.
- Strips the trailing padding and forwards payload bytes downstream, reporting per-frame byte counts.
- Sits between the trace sink/readback path and the trace decoder. Configured by the same frame fields the packetizer uses: frame_mode_enable, frame_length, frame_fill_byte, frame_closure_mode.

Parameters:
- MAX_FRAME_LENGTH_IN_BYTES, 512, largest legal frame; sets FLW = $clog2(MAX_FRAME_LENGTH_IN_BYTES)+1 = 10.
- FRAME_CNT_W, 16, width of the frames-completed counter.

Ports:
- clock  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- frame_mode_enable  in  1  1 = deframe; 0 = transparent bypass.
- frame_closure_mode  in  1  0 = frames always frame_length bytes; 1 = in_last may close a frame early.
- frame_length  in  FLW  frame size in bytes.
- frame_fill_byte  in  8  padding byte value.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_last  in  1  early frame close; honoured only when frame_closure_mode=1.
- in_ready  out  1  input accept.
- out_valid  out  1  payload byte valid.
- out_data  out  8  payload byte.
- out_ready  in  1  downstream accept.
- frame_done  out  1  one-cycle pulse at frame close.
- frame_data_bytes  out  FLW  payload bytes of the frame just closed; valid with frame_done.
- frame_cnt  out  FRAME_CNT_W  frames closed since reset; wraps.
- cfg_err  out  1  sticky; frame_length==0 or frame_length>MAX seen at a frame start.

Behaviour:
- Clock and reset: one clock, named clock; reset is synchronous and active-high, named reset.
- Reset values: all outputs 0, except in_ready=0 during reset and 1 on the first cycle after.
- Reset mid-frame discards all partial state; nothing is replayed.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - out_data and out_valid hold stable while out_valid & !out_ready.
- Output stage: single output register, 1-cycle latency from accept to out_valid.
  - in_ready = (state != REPLAY) & (!out_valid | out_ready).
- Config sampling: config is sampled only at frame start (byte_cnt==0) into shadow registers; changes mid-frame take effect next frame.
  - Invalid frame_length: set cfg_err and use MAX_FRAME_LENGTH_IN_BYTES.
- Bypass (shadow mode=0): every accepted byte is forwarded. No counting, no frame_done.
- Deframe state machine: states IDLE, IN_FRAME, REPLAY.
  - Counters: byte_cnt (bytes accepted in frame), run_cnt (consecutive pending fill bytes), data_cnt (bytes forwarded).
  - IDLE -> IN_FRAME on first accepted byte.
- Accepted byte equal to fill (IDLE or IN_FRAME): run_cnt++, nothing output.
- Accepted non-fill byte with run_cnt==0: forward it, data_cnt++.
- Accepted non-fill byte with run_cnt>0: hold the byte in a pending register and go to REPLAY.
  - REPLAY emits run_cnt fill bytes, one per output slot, then the held byte; data_cnt is incremented for each.
  - Then return to IN_FRAME with run_cnt=0. No input is accepted in REPLAY.
- Frame close occurs when byte_cnt reaches the shadow length, or on accepted in_last (closure_mode=1):
  - the pending run is discarded;
  - frame_done pulses the cycle after the closing accept, with frame_data_bytes = data_cnt (payload only);
  - frame_cnt++, counters clear, state returns to IDLE.
- If the closing byte is a non-fill byte with run_cnt>0, it replays first; frame_done fires the cycle after the final replayed byte is loaded.
- A frame of all fill bytes gives frame_done with frame_data_bytes=0 and no output.
- in_last while closure_mode=0 is ignored.
- run_cnt never exceeds the frame length (the frame closes first).
- frame_cnt wraps at 2^FRAME_CNT_W-1 -> 0.
- Backpressure during REPLAY stalls REPLAY without loss.

Test Plan:
- len=8, fill=0xA5; input 01 02 03 A5 A5 A5 A5 A5 -> out 01 02 03; frame_done with frame_data_bytes=3; frame_cnt=1.
- len=8, fill=0xA5; input 01 A5 A5 02 A5 A5 A5 A5 -> out 01 A5 A5 02; frame_data_bytes=4; in_ready low for 2 cycles during REPLAY.
- closure_mode=1, len=16; input 11 22 A5 with in_last on A5 -> out 11 22; frame_done with frame_data_bytes=2, after 3 bytes.
- frame_length=0 -> cfg_err=1, frame closes after 512 bytes; frame_length changed mid-frame from 8 to 4 -> current frame still 8 bytes, next frame 4.
- frame_mode_enable=0; input 00 A5 A5 -> out 00 A5 A5 unchanged, frame_done never pulses.
- out_ready held low 5 cycles mid-REPLAY, then reset asserted mid-frame -> no byte lost or duplicated before reset; all outputs 0 after reset; next frame decodes cleanly.

Source files
------------

// File: rtl/dfd_trace_deframer.sv
// Trace frame deframer: strips tail fill padding from fixed-length frames and
// forwards payload bytes through a single output register with per-frame byte counts.
module dfd_trace_deframer #(
    parameter int MAX_FRAME_LENGTH_IN_BYTES = 512,
    parameter int FRAME_CNT_W               = 16,
    localparam int FLW = $clog2(MAX_FRAME_LENGTH_IN_BYTES) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_mode_enable,
    input  logic                   frame_closure_mode,
    input  logic [FLW-1:0]         frame_length,
    input  logic [7:0]             frame_fill_byte,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   frame_done,
    output logic [FLW-1:0]         frame_data_bytes,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   cfg_err
);

    localparam logic [FLW-1:0] MAX_LEN = FLW'(MAX_FRAME_LENGTH_IN_BYTES);

    typedef enum logic [1:0] {IDLE, IN_FRAME, REPLAY} state_t;

    state_t                 state, state_nxt;
    logic [FLW-1:0]         byte_cnt, byte_cnt_nxt;
    logic [FLW-1:0]         run_cnt, run_cnt_nxt;
    logic [FLW-1:0]         data_cnt, data_cnt_nxt;
    logic                   sh_mode, sh_mode_nxt;
    logic                   sh_close, sh_close_nxt;
    logic [FLW-1:0]         sh_len, sh_len_nxt;
    logic [7:0]             sh_fill, sh_fill_nxt;
    logic [7:0]             pend_p0, pend_p0_nxt;
    logic                   close_pend, close_pend_nxt;
    logic                   vld_p1, vld_p1_nxt;
    logic [7:0]             data_p1, data_p1_nxt;
    logic                   done_p1, done_p1_nxt;
    logic [FLW-1:0]         fbytes_p1, fbytes_p1_nxt;
    logic [FRAME_CNT_W-1:0] fcnt, fcnt_nxt;
    logic                   cfg_err_q, cfg_err_nxt;

    logic                   slot_free, accept, frame_start, len_bad;
    logic                   cur_mode, cur_close, is_fill, closing, do_close;
    logic [FLW-1:0]         cur_len, close_bytes;
    logic [7:0]             cur_fill;

    // Live config applies to the first byte of a frame; shadows cover the rest.
    always_comb begin
        slot_free   = !vld_p1 || out_ready;
        in_ready    = !reset && (state != REPLAY) && slot_free;
        accept      = in_valid && in_ready;
        frame_start = (byte_cnt == '0);
        len_bad     = (frame_length == '0) || (frame_length > MAX_LEN);
        cur_mode    = frame_start ? frame_mode_enable  : sh_mode;
        cur_close   = frame_start ? frame_closure_mode : sh_close;
        cur_fill    = frame_start ? frame_fill_byte    : sh_fill;
        cur_len     = frame_start ? (len_bad ? MAX_LEN : frame_length) : sh_len;
        is_fill     = (in_data == cur_fill);
        closing     = ((byte_cnt + FLW'(1)) == cur_len) || (cur_close && in_last);
    end

    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        run_cnt_nxt    = run_cnt;
        data_cnt_nxt   = data_cnt;
        sh_mode_nxt    = sh_mode;
        sh_close_nxt   = sh_close;
        sh_len_nxt     = sh_len;
        sh_fill_nxt    = sh_fill;
        pend_p0_nxt    = pend_p0;
        close_pend_nxt = close_pend;
        vld_p1_nxt     = vld_p1 && !out_ready;
        data_p1_nxt    = data_p1;
        done_p1_nxt    = 1'b0;
        fbytes_p1_nxt  = fbytes_p1;
        fcnt_nxt       = fcnt;
        cfg_err_nxt    = cfg_err_q;
        do_close       = 1'b0;
        close_bytes    = data_cnt;

        case (state)
            IDLE, IN_FRAME: begin
                if (accept) begin
                    if (frame_start) begin
                        sh_mode_nxt  = cur_mode;
                        sh_close_nxt = cur_close;
                        sh_len_nxt   = cur_len;
                        sh_fill_nxt  = cur_fill;
                        if (cur_mode && len_bad) cfg_err_nxt = 1'b1;
                    end
                    if (!cur_mode) begin
                        vld_p1_nxt  = 1'b1;
                        data_p1_nxt = in_data;
                    end else begin
                        state_nxt    = IN_FRAME;
                        byte_cnt_nxt = byte_cnt + FLW'(1);
                        if (is_fill) begin
                            if (closing) do_close = 1'b1;
                            else         run_cnt_nxt = run_cnt + FLW'(1);
                        end else if (run_cnt == '0) begin
                            vld_p1_nxt   = 1'b1;
                            data_p1_nxt  = in_data;
                            data_cnt_nxt = data_cnt + FLW'(1);
                            close_bytes  = data_cnt + FLW'(1);
                            do_close     = closing;
                        end else begin
                            // The accept slot already carries the first fill of the run.
                            vld_p1_nxt     = 1'b1;
                            data_p1_nxt    = cur_fill;
                            data_cnt_nxt   = data_cnt + FLW'(1);
                            run_cnt_nxt    = run_cnt - FLW'(1);
                            pend_p0_nxt    = in_data;
                            close_pend_nxt = closing;
                            state_nxt      = REPLAY;
                        end
                    end
                end
            end
            REPLAY: begin
                if (slot_free) begin
                    vld_p1_nxt   = 1'b1;
                    data_cnt_nxt = data_cnt + FLW'(1);
                    if (run_cnt != '0) begin
                        data_p1_nxt = sh_fill;
                        run_cnt_nxt = run_cnt - FLW'(1);
                    end else begin
                        data_p1_nxt = pend_p0;
                        state_nxt   = IN_FRAME;
                        close_bytes = data_cnt + FLW'(1);
                        do_close    = close_pend;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (do_close) begin
            done_p1_nxt    = 1'b1;
            fbytes_p1_nxt  = close_bytes;
            fcnt_nxt       = fcnt + FRAME_CNT_W'(1);
            byte_cnt_nxt   = '0;
            run_cnt_nxt    = '0;
            data_cnt_nxt   = '0;
            close_pend_nxt = 1'b0;
            state_nxt      = IDLE;
        end
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            run_cnt    <= '0;
            data_cnt   <= '0;
            close_pend <= 1'b0;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            done_p1    <= 1'b0;
            fbytes_p1  <= '0;
            fcnt       <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            run_cnt    <= run_cnt_nxt;
            data_cnt   <= data_cnt_nxt;
            close_pend <= close_pend_nxt;
            vld_p1     <= vld_p1_nxt;
            data_p1    <= data_p1_nxt;
            done_p1    <= done_p1_nxt;
            fbytes_p1  <= fbytes_p1_nxt;
            fcnt       <= fcnt_nxt;
            cfg_err_q  <= cfg_err_nxt;
        end
    end

    // Shadow config and held byte are only read after being loaded in the same frame
    always_ff @(posedge clock) begin
        sh_mode  <= sh_mode_nxt;
        sh_close <= sh_close_nxt;
        sh_len   <= sh_len_nxt;
        sh_fill  <= sh_fill_nxt;
        pend_p0  <= pend_p0_nxt;
    end

    assign out_valid        = vld_p1;
    assign out_data         = data_p1;
    assign frame_done       = done_p1;
    assign frame_data_bytes = fbytes_p1;
    assign frame_cnt        = fcnt;
    assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_dfd_trace_deframer.sv
// Bench for dfd_trace_deframer: frame-buffer reference model fed by accepted bytes,
// compared against DUT outputs each cycle, plus directed literal expectations.
module tb_dfd_trace_deframer;

    localparam int FLW = 10;
    localparam int CW  = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           frame_mode_enable, frame_closure_mode;
    logic [FLW-1:0] frame_length;
    logic [7:0]     frame_fill_byte;
    logic           in_valid, in_last, in_ready;
    logic [7:0]     in_data;
    logic           out_valid, out_ready;
    logic [7:0]     out_data;
    logic           frame_done;
    logic [FLW-1:0] frame_data_bytes;
    logic [CW-1:0]  frame_cnt;
    logic           cfg_err;

    dfd_trace_deframer #(.MAX_FRAME_LENGTH_IN_BYTES(512), .FRAME_CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .frame_mode_enable(frame_mode_enable), .frame_closure_mode(frame_closure_mode),
        .frame_length(frame_length), .frame_fill_byte(frame_fill_byte),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .frame_done(frame_done), .frame_data_bytes(frame_data_bytes),
        .frame_cnt(frame_cnt), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    typedef struct {int bytes; int cnt;} rec_t;

    int   n_checks = 0, n_fail = 0;
    logic [7:0] exp_q[$], got_q[$], m_buf[$];
    rec_t rec_q[$];
    int   m_pos = 0, m_emit = 0, m_len = 0, exp_cnt = 0;
    bit   m_mode, m_close, exp_cfg_err = 0;
    logic [7:0] m_fill;
    int   n_done = 0, last_bytes = -1, last_cnt = -1, lowcnt = 0;
    bit   stab_pend = 0, rdy_rand = 0;
    logic [7:0] stab_data;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: a frame's payload is everything up to its last non-fill byte.
    task automatic model_accept(input logic [7:0] b, input logic l);
        if (m_pos == 0) begin
            m_mode  = frame_mode_enable;
            m_close = frame_closure_mode;
            m_fill  = frame_fill_byte;
            if (frame_length == 0 || frame_length > 512) begin
                m_len = 512;
                if (m_mode) exp_cfg_err = 1;
            end else begin
                m_len = int'(frame_length);
            end
        end
        if (!m_mode) begin
            exp_q.push_back(b);
        end else begin
            m_buf.push_back(b);
            m_pos++;
            if (b != m_fill) begin
                while (m_emit < m_buf.size()) begin
                    exp_q.push_back(m_buf[m_emit]);
                    m_emit++;
                end
            end
            if (m_pos == m_len || (m_close && l)) begin
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                rec_q.push_back('{m_emit, exp_cnt});
                m_buf.delete();
                m_pos  = 0;
                m_emit = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete(); rec_q.delete(); m_buf.delete();
                m_pos = 0; m_emit = 0; exp_cnt = 0; exp_cfg_err = 0; stab_pend = 0;
            end else begin
                if (!in_ready) lowcnt++;
                if (stab_pend) begin
                    check("out_hold_valid", out_valid, 1);
                    check("out_hold_data", out_data, stab_data);
                end
                if (out_valid && out_ready) begin
                    check("out_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
                    got_q.push_back(out_data);
                end
                stab_pend = out_valid && !out_ready;
                stab_data = out_data;
                if (frame_done) begin
                    check("frame_expected", rec_q.size() != 0, 1);
                    if (rec_q.size() != 0) begin
                        rec_t r;
                        r = rec_q.pop_front();
                        check("frame_data_bytes", frame_data_bytes, r.bytes);
                        check("frame_cnt", frame_cnt, r.cnt);
                    end
                    n_done++;
                    last_bytes = frame_data_bytes;
                    last_cnt   = frame_cnt;
                end
                check("cfg_err", cfg_err, exp_cfg_err);
                if (in_valid && in_ready) model_accept(in_data, in_last);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        bit ok = 0;
        in_valid = 1; in_data = b; in_last = l;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                step();
            end
        end
        check("send_accepted", ok, 1);
        in_valid = 0; in_last = 0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int k = 0; k < 600 && !ok; k++) begin
            step();
            if (exp_q.size() == 0 && rec_q.size() == 0 && !out_valid) ok = 1;
        end
        check("drain_done", ok, 1);
    endtask

    task automatic apply_reset();
        reset = 1; in_valid = 0; in_last = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_data_bytes", frame_data_bytes, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_cfg_err", cfg_err, 0);
        step();
        reset = 0;
        @(negedge clock);
        check("in_ready_after_reset", in_ready, 1);
        step();
    endtask

    task automatic check_got(input string name, input logic [7:0] e[], input int n);
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) check(name, got_q[i], e[i]);
    endtask

    task automatic cfg(input bit mode, input bit cl, input int len, input logic [7:0] fill);
        frame_mode_enable = mode; frame_closure_mode = cl;
        frame_length = FLW'(len); frame_fill_byte = fill;
    endtask

    logic [7:0] e1[] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] e2[] = '{8'h01, 8'hA5, 8'hA5, 8'h02};
    logic [7:0] e3[] = '{8'h11, 8'h22};
    logic [7:0] e5[] = '{8'h00, 8'hA5, 8'hA5};
    logic [7:0] e6[] = '{8'h01, 8'hA5, 8'hA5, 8'hA5, 8'h02};
    logic [7:0] t1[] = '{8'h01, 8'h02, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    logic [7:0] t2[] = '{8'h01, 8'hA5, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hA5, 8'hA5};

    initial begin
        int d0;
        logic [7:0] b;
        reset = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
        cfg(1, 0, 8, 8'hA5);
        step();
        apply_reset();

        // Plain tail padding
        got_q.delete();
        foreach (t1[i]) send(t1[i], 0);
        drain();
        check_got("t1_out", e1, 3);
        check("t1_bytes", last_bytes, 3);
        check("t1_cnt", last_cnt, 1);

        // Interior fill run replayed; REPLAY stalls the input for two cycles
        got_q.delete(); lowcnt = 0;
        foreach (t2[i]) send(t2[i], 0);
        drain();
        check_got("t2_out", e2, 4);
        check("t2_bytes", last_bytes, 4);
        check("t2_in_ready_low", lowcnt, 2);

        // Early close on in_last
        got_q.delete(); cfg(1, 1, 16, 8'hA5);
        send(8'h11, 0); send(8'h22, 0); send(8'hA5, 1);
        drain();
        check_got("t3_out", e3, 2);
        check("t3_bytes", last_bytes, 2);
        check("t3_cnt", last_cnt, 3);

        // Bypass
        got_q.delete(); d0 = n_done; cfg(0, 0, 8, 8'hA5);
        send(8'h00, 0); send(8'hA5, 0); send(8'hA5, 1);
        drain();
        check_got("t5_out", e5, 3);
        check("t5_no_frame_done", n_done, d0);

        // Random traffic, backpressure and mid-frame config changes
        rdy_rand = 1;
        cfg(1, 0, 6, 8'hA5);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                frame_mode_enable  = ($urandom_range(0, 7) != 0);
                frame_closure_mode = 1'($urandom_range(0, 1));
                frame_length       = FLW'($urandom_range(1, 12));
                case ($urandom_range(0, 2))
                    0:       frame_fill_byte = 8'hA5;
                    1:       frame_fill_byte = 8'h00;
                    default: frame_fill_byte = 8'hFF;
                endcase
            end
            b = ($urandom_range(0, 1) == 0) ? frame_fill_byte : 8'($urandom_range(0, 255));
            send(b, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 7) == 0) step();
        end
        rdy_rand = 0; out_ready = 1;
        drain();
        apply_reset();

        // Invalid length falls back to 512; length change mid-frame waits for next frame
        cfg(1, 0, 0, 8'hA5);
        for (int i = 0; i < 512; i++) begin
            if (i == 100) frame_length = 8;
            send(8'h11, 0);
        end
        drain();
        check("t4_cfg_err", cfg_err, 1);
        check("t4_bytes_512", last_bytes, 512);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) frame_length = 4;
            send(8'h22, 0);
        end
        drain();
        check("t4_bytes_8", last_bytes, 8);
        for (int i = 0; i < 4; i++) send(8'h33, 0);
        drain();
        check("t4_bytes_4", last_bytes, 4);

        // Backpressure mid-REPLAY, then reset mid-frame
        got_q.delete(); d0 = n_done; cfg(1, 0, 8, 8'hA5);
        send(8'h01, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'h02, 0);
        out_ready = 0;
        repeat (5) step();
        out_ready = 1;
        repeat (10) step();
        check_got("t6_out", e6, 5);
        check("t6_no_close", n_done, d0);
        apply_reset();
        got_q.delete();
        send(8'h07, 0);
        for (int i = 0; i < 7; i++) send(8'hA5, 0);
        drain();
        check("t6_after_bytes", last_bytes, 1);
        check("t6_after_cnt", last_cnt, 1);

        // Frame counter wrap
        d0 = n_done; cfg(1, 0, 1, 8'hA5);
        for (int i = 0; i < 15; i++) send(8'h33, 0);
        drain();
        check("wrap_frames", n_done - d0, 15);
        check("wrap_cnt", last_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
